mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 16, address width shared with memory port.
REQ-002 Parameter DATA_W, 16, data word width shared with memory port.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high; sampled on rising edge of clock.
REQ-005 f_req  in  1  instruction-fetch read request; held until f_ack.
REQ-006 f_addr  in  ADDR_W  fetch address; stable while f_req high.
REQ-007 f_ack  out  1  one-cycle fetch completion pulse.
REQ-008 f_rdata  out  DATA_W  fetched word; valid in f_ack cycle, held until next f_ack.
REQ-009 d_req  in  1  data load/store request; held until d_ack.
REQ-010 d_we  in  1  1 = store, 0 = load; stable while d_req high.
REQ-011 d_addr  in  ADDR_W  data address; stable while d_req high.
REQ-012 d_wdata  in  DATA_W  store data; stable while d_req high.
REQ-013 d_ack  out  1  one-cycle data completion pulse.
REQ-014 d_rdata  out  DATA_W  loaded word; valid in d_ack cycle, held until next load d_ack.
REQ-015 mem_enable  out  1  to memory enable; registered.
REQ-016 mem_writeEnable  out  1  to memory writeEnable; registered.
REQ-017 mem_address  out  ADDR_W  to memory address; registered.
REQ-018 mem_writeData  out  DATA_W  to memory writeData; registered.
REQ-019 mem_readData  in  DATA_W  from memory readData; valid one cycle after an enabled read cycle.

Function
REQ-020 FSM states IDLE, ISSUE, RESP, ACK; IDLE->ISSUE on any pending req, ISSUE->RESP, RESP->ACK, ACK->IDLE unconditionally.
REQ-021 In IDLE with a pending req, the arbiter latches winner's address/we/wdata into mem_* registers and a grant register at the edge leaving IDLE.
REQ-022 mem_enable = 1 only in ISSUE; mem_writeEnable = 1 only in ISSUE for a data store; fetch always drives mem_writeEnable = 0.
REQ-023 At the edge leaving RESP, mem_readData is captured into granted port's rdata for loads/fetches; stores leave d_rdata unchanged.
REQ-024 Granted port's ack is high exactly in the ACK cycle; the other ack stays 0; never both acks high.
REQ-025 Latency: req first sampled in IDLE cycle T -> ack in cycle T+3; peak throughput one access per 4 cycles.
REQ-026 Only one request pending -> it wins.
REQ-027 Both pending -> grant the port not granted last (last_grant register, updated at each grant); last_grant resets to fetch, so data wins first tie after reset.
REQ-028 Requester updates req/operands only at edge ending its ack cycle; a req still high in the following IDLE cycle is a new request.
REQ-029 Req dropped or operands changed after grant do not abort or alter the transaction; ack still pulses with latched-operand result.
REQ-030 Address arithmetic none; addresses pass unmodified, full 0..2^ADDR_W-1 range, no wrap handling.

Reset
REQ-031 Reset -> state IDLE, mem_enable 0, mem_writeEnable 0, mem_address 0, mem_writeData 0, f_ack 0, d_ack 0, f_rdata 0, d_rdata 0, last_grant = fetch.
REQ-032 Reset mid-operation abandons transaction, no ack issued; a store in ISSUE during the reset edge is still written by memory (mem_enable was high that cycle).
REQ-033 Requests high during reset are ignored; first sampled in the first IDLE cycle after reset deasserts.

Verification
REQ-034 Fetch only: mem[0x0010]=0xBEEF, f_req=1 f_addr=0x0010 at T -> mem_enable=1 addr 0x0010 at T+1, f_ack=1 f_rdata=0xBEEF at T+3.
REQ-035 Store then load: d_we=1 d_addr=0x2000 d_wdata=0x1234 -> d_ack at T+3, d_rdata unchanged; then load 0x2000 -> d_rdata=0x1234 with d_ack.
REQ-036 Tie after reset: f_req and d_req both held -> order data, fetch, data, fetch; acks 4 cycles apart, never simultaneous.
REQ-037 Req withdrawn: f_req high one cycle only at T -> f_ack still pulses at T+3 with correct data; no second access.
REQ-038 Reset in RESP of a fetch -> no f_ack, all outputs 0 next cycle, pending d_req served starting first IDLE cycle after reset.
REQ-039 Address extremes: fetch 0x0000 and 0xFFFF return stored words; mem_address matches exactly.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data load/store share one
// synchronous single-port memory, one access per four-cycle IDLE/ISSUE/RESP/ACK pass.
module mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   // Handshake: a requester raises req with stable operands and holds both
   // until it sees its one-cycle ack; req still high in the IDLE cycle after
   // the ack is taken as a fresh request.
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_ack,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_enable,
   output logic              mem_writeEnable,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_writeData,
   input  logic [DATA_W-1:0] mem_readData,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2,
      ACK   = 2'd3
   } state_t;

   state_t state;
   logic   grant_data;
   logic   grant_we;
   logic   last_grant_data;
   logic   pick_data;

   // Data wins when it is alone, or on a tie when fetch had the last grant.
   always_comb begin
      pick_data = d_req && (!f_req || !last_grant_data);
   end

   assign dbg_state = state;

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         grant_data      <= 1'b0;
         grant_we        <= 1'b0;
         last_grant_data <= 1'b0;
         mem_enable      <= 1'b0;
         mem_writeEnable <= 1'b0;
         mem_address     <= '0;
         mem_writeData   <= '0;
         f_ack           <= 1'b0;
         d_ack           <= 1'b0;
         f_rdata         <= '0;
         d_rdata         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (f_req || d_req) begin
                  state           <= ISSUE;
                  grant_data      <= pick_data;
                  grant_we        <= pick_data && d_we;
                  last_grant_data <= pick_data;
                  mem_enable      <= 1'b1;
                  mem_writeEnable <= pick_data && d_we;
                  mem_address     <= pick_data ? d_addr : f_addr;
                  if (pick_data) begin
                     mem_writeData <= d_wdata;
                  end
               end
            end
            ISSUE: begin
               state           <= RESP;
               mem_enable      <= 1'b0;
               mem_writeEnable <= 1'b0;
            end
            RESP: begin
               // Memory read data is valid now, one cycle after the enabled cycle.
               state <= ACK;
               if (grant_data) begin
                  d_ack <= 1'b1;
                  if (!grant_we) begin
                     d_rdata <= mem_readData;
                  end
               end else begin
                  f_ack   <= 1'b1;
                  f_rdata <= mem_readData;
               end
            end
            ACK: begin
               state <= IDLE;
               f_ack <= 1'b0;
               d_ack <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous memory and an
// ordered completion scoreboard ({is_data, rdata} per expected ack).
module tb_mem_arbiter;

   logic        clock;
   logic        reset;
   logic        f_req;
   logic [15:0] f_addr;
   logic        f_ack;
   logic [15:0] f_rdata;
   logic        d_req;
   logic        d_we;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_ack;
   logic [15:0] d_rdata;
   logic        mem_enable;
   logic        mem_writeEnable;
   logic [15:0] mem_address;
   logic [15:0] mem_writeData;
   logic [15:0] mem_readData;
   logic [1:0]  dbg_state;

   logic [15:0] mem [0:65535];
   int          access_cnt;
   logic [16:0] exp_q[$];
   int          total;
   int          bad;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
      .clock           (clock),
      .reset           (reset),
      .f_req           (f_req),
      .f_addr          (f_addr),
      .f_ack           (f_ack),
      .f_rdata         (f_rdata),
      .d_req           (d_req),
      .d_we            (d_we),
      .d_addr          (d_addr),
      .d_wdata         (d_wdata),
      .d_ack           (d_ack),
      .d_rdata         (d_rdata),
      .mem_enable      (mem_enable),
      .mem_writeEnable (mem_writeEnable),
      .mem_address     (mem_address),
      .mem_writeData   (mem_writeData),
      .mem_readData    (mem_readData),
      .dbg_state       (dbg_state)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Synchronous memory: read data appears the cycle after an enabled read.
   always @(posedge clock) begin
      if (mem_enable === 1'b1) begin
         access_cnt <= access_cnt + 1;
         if (mem_writeEnable === 1'b1) begin
            mem[mem_address] <= mem_writeData;
         end else begin
            mem_readData <= mem[mem_address];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Scoreboard: every ack pops the oldest expected completion.
   always @(negedge clock) begin
      logic [16:0] e;
      if (f_ack === 1'b1 || d_ack === 1'b1) begin
         chk("ack_exclusive", {31'd0, f_ack & d_ack}, 32'd0);
         chk("ack_expected", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_port", {31'd0, d_ack}, {31'd0, e[16]});
            chk("sb_rdata", {16'd0, (d_ack === 1'b1) ? d_rdata : f_rdata}, {16'd0, e[15:0]});
         end
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_mem_enable"}, {31'd0, mem_enable}, 32'd0);
      chk({tag, "_mem_we"}, {31'd0, mem_writeEnable}, 32'd0);
      chk({tag, "_mem_address"}, {16'd0, mem_address}, 32'd0);
      chk({tag, "_mem_wdata"}, {16'd0, mem_writeData}, 32'd0);
      chk({tag, "_f_ack"}, {31'd0, f_ack}, 32'd0);
      chk({tag, "_d_ack"}, {31'd0, d_ack}, 32'd0);
      chk({tag, "_f_rdata"}, {16'd0, f_rdata}, 32'd0);
      chk({tag, "_d_rdata"}, {16'd0, d_rdata}, 32'd0);
      chk({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
   endtask

   // driver tasks
   task automatic fetch_txn(input logic [15:0] addr, input logic [15:0] exp_rd);
      int lat;
      f_req  = 1'b1;
      f_addr = addr;
      exp_q.push_back({1'b0, exp_rd});
      lat = 0;
      do begin
         step(1);
         lat++;
         if (lat == 1) begin
            chk("f_issue_en", {31'd0, mem_enable}, 32'd1);
            chk("f_issue_addr", {16'd0, mem_address}, {16'd0, addr});
            chk("f_issue_we", {31'd0, mem_writeEnable}, 32'd0);
         end
      end while (f_ack !== 1'b1 && lat < 8);
      chk("f_latency", lat, 32'd3);
      chk("f_rdata", {16'd0, f_rdata}, {16'd0, exp_rd});
      f_req = 1'b0;
      step(1);
   endtask

   task automatic data_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] exp_rd);
      int lat;
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = addr;
      d_wdata = wdata;
      exp_q.push_back({1'b1, exp_rd});
      lat = 0;
      do begin
         step(1);
         lat++;
         if (lat == 1) begin
            chk("d_issue_addr", {16'd0, mem_address}, {16'd0, addr});
            chk("d_issue_we", {31'd0, mem_writeEnable}, {31'd0, we});
            if (we) begin
               chk("d_issue_wdata", {16'd0, mem_writeData}, {16'd0, wdata});
            end
         end
      end while (d_ack !== 1'b1 && lat < 8);
      chk("d_latency", lat, 32'd3);
      chk("d_rdata", {16'd0, d_rdata}, {16'd0, exp_rd});
      d_req = 1'b0;
      step(1);
   endtask

   initial begin
      logic [15:0] a;
      logic [15:0] w;
      logic [15:0] d_model;
      int          acc0;
      int          budget;

      total = 0;
      bad = 0;
      access_cnt = 0;
      mem_readData = 16'h0000;
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      mem[16'h0010] = 16'hBEEF;
      mem[16'h0100] = 16'hAAAA;
      mem[16'h0200] = 16'h5555;
      mem[16'h0300] = 16'h1357;
      mem[16'h0000] = 16'h0F0F;
      mem[16'hFFFF] = 16'hF00D;

      // Reset with a fetch request already high: it must be ignored until IDLE.
      reset = 1'b1;
      f_req = 1'b1;
      f_addr = 16'h0010;
      d_req = 1'b0;
      d_we = 1'b0;
      d_addr = 16'h0000;
      d_wdata = 16'h0000;
      step(2);
      check_all_zero("reset");

      // Fetch only: first sampled in cycle T, issue at T+1, ack at T+3.
      reset = 1'b0;
      exp_q.push_back({1'b0, 16'hBEEF});
      step(1);
      chk("fetch_en_t1", {31'd0, mem_enable}, 32'd1);
      chk("fetch_addr_t1", {16'd0, mem_address}, 32'h0010);
      chk("fetch_we_t1", {31'd0, mem_writeEnable}, 32'd0);
      step(1);
      chk("fetch_en_t2", {31'd0, mem_enable}, 32'd0);
      chk("fetch_ack_t2", {31'd0, f_ack}, 32'd0);
      step(1);
      chk("fetch_ack_t3", {31'd0, f_ack}, 32'd1);
      chk("fetch_rdata_t3", {16'd0, f_rdata}, 32'hBEEF);
      chk("fetch_dack_t3", {31'd0, d_ack}, 32'd0);
      f_req = 1'b0;
      step(1);
      chk("fetch_ack_t4", {31'd0, f_ack}, 32'd0);
      chk("fetch_hold_t4", {16'd0, f_rdata}, 32'hBEEF);

      // Store leaves d_rdata alone, load returns stored word.
      data_txn(1'b1, 16'h2000, 16'h1234, 16'h0000);
      chk("store_landed", {16'd0, mem[16'h2000]}, 32'h1234);
      data_txn(1'b0, 16'h2000, 16'h0000, 16'h1234);

      // Random store/load pairs.
      d_model = 16'h1234;
      for (int i = 0; i < 4; i++) begin
         a = 16'($urandom_range(16'h4000, 16'h7FFF));
         w = 16'($urandom_range(0, 16'hFFFF));
         data_txn(1'b1, a, w, d_model);
         data_txn(1'b0, a, 16'h0000, w);
         d_model = w;
      end

      // Address extremes.
      fetch_txn(16'h0000, 16'h0F0F);
      fetch_txn(16'hFFFF, 16'hF00D);

      // Request withdrawn after one cycle and operands changed: still completes once.
      acc0 = access_cnt;
      f_req = 1'b1;
      f_addr = 16'h0300;
      exp_q.push_back({1'b0, 16'h1357});
      step(1);
      f_req = 1'b0;
      f_addr = 16'h0301;
      chk("wd_addr", {16'd0, mem_address}, 32'h0300);
      step(2);
      chk("wd_ack", {31'd0, f_ack}, 32'd1);
      chk("wd_rdata", {16'd0, f_rdata}, 32'h1357);
      step(4);
      chk("wd_accesses", access_cnt - acc0, 32'd1);
      chk("wd_idle", {30'd0, dbg_state}, 32'd0);

      // Tie after reset: data, fetch, data, fetch, four cycles apart.
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      f_req = 1'b1;
      f_addr = 16'h0100;
      d_req = 1'b1;
      d_we = 1'b0;
      d_addr = 16'h0200;
      exp_q.push_back({1'b1, 16'h5555});
      exp_q.push_back({1'b0, 16'hAAAA});
      exp_q.push_back({1'b1, 16'h5555});
      exp_q.push_back({1'b0, 16'hAAAA});
      for (int k = 1; k <= 17; k++) begin
         step(1);
         chk("tie_d_ack", {31'd0, d_ack}, {31'd0, (k == 3 || k == 11)});
         chk("tie_f_ack", {31'd0, f_ack}, {31'd0, (k == 7 || k == 15)});
         if (k == 15) begin
            f_req = 1'b0;
            d_req = 1'b0;
         end
      end

      // Reset during RESP of a fetch: no ack, then the pending load is served.
      f_req = 1'b1;
      f_addr = 16'h0010;
      step(1);
      d_req = 1'b1;
      d_we = 1'b0;
      d_addr = 16'h0200;
      step(1);
      chk("rst_resp_state", {30'd0, dbg_state}, 32'd2);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      f_req = 1'b0;
      check_all_zero("midreset");
      exp_q.push_back({1'b1, 16'h5555});
      step(1);
      chk("rst_load_en", {31'd0, mem_enable}, 32'd1);
      chk("rst_load_addr", {16'd0, mem_address}, 32'h0200);
      step(2);
      chk("rst_load_ack", {31'd0, d_ack}, 32'd1);
      chk("rst_load_fack", {31'd0, f_ack}, 32'd0);
      chk("rst_load_rdata", {16'd0, d_rdata}, 32'h5555);
      d_req = 1'b0;
      step(1);

      // Drain: every expected completion must have been seen.
      budget = 0;
      while (exp_q.size() != 0 && budget < 10) begin
         step(1);
         budget++;
      end
      chk("exp_q_empty", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
